// File: rtl/text_screen_pkg.sv
// Shared constants, FSM encoding and cell indexing
// for the 4x8 character-cell text screen.
package text_screen_pkg;

  localparam int COLS   = 4;
  localparam int ROWS   = 8;
  localparam int CODE_W = 7;
  localparam int CELLS  = COLS * ROWS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  // row*4 + col with power-of-two geometry
  function automatic logic [4:0] cell_idx(
    input logic [1:0] col,
    input logic [2:0] row
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/scan_pointer.sv
// Round-robin cell pointer, column-fastest,
// wrapping from (3,7) back to (0,0).
module scan_pointer
  import text_screen_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       adv,
  output logic [1:0] col,
  output logic [2:0] row
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      col <= col + 2'd1;
      if (col == 2'(COLS - 1))
        row <= row + 3'd1;
    end
  end

endmodule

// File: rtl/char_draw_scheduler.sv
// Text buffer with per-cell dirty bits; hands dirty
// cells one at a time to the glyph drawer.
module char_draw_scheduler
  import text_screen_pkg::*;
#(
  parameter logic [CODE_W-1:0] RESET_CODE = 7'h20
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [1:0]        wr_col,
  input  logic [2:0]        wr_row,
  input  logic [CODE_W-1:0] wr_code,
  input  logic              refresh_all,
  output logic              draw_start,
  output logic [1:0]        draw_col,
  output logic [2:0]        draw_row,
  output logic [CODE_W-1:0] draw_code,
  input  logic              draw_done,
  output logic              busy,
  output logic              frame_done
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CELLS-1:0]  dirty;
  logic [CELLS-1:0]  dirty_nxt;
  logic [CELLS-1:0]  set_v;
  logic [CELLS-1:0]  clr_v;
  logic [CODE_W-1:0] cbuf [CELLS];
  logic [1:0]        pcol;
  logic [2:0]        prow;
  logic [4:0]        pidx;
  logic              hit;
  logic              adv;

  scan_pointer u_ptr (
    .clock  (clock),
    .resetn (resetn),
    .adv    (adv),
    .col    (pcol),
    .row    (prow)
  );

  assign pidx = cell_idx(pcol, prow);
  assign hit  = (state == S_SCAN) && dirty[pidx];

  // sets are applied after the clear so they always win
  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (refresh_all)
      set_v = '1;
    if (wr_en)
      set_v[cell_idx(wr_col, wr_row)] = 1'b1;
    if (hit)
      clr_v[pidx] = 1'b1;
    dirty_nxt = (dirty & ~clr_v) | set_v;
  end

  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    unique case (1'b1)
      state == S_IDLE: begin
        if (|dirty)
          state_nxt = S_SCAN;
      end
      state == S_SCAN: begin
        if (hit)
          state_nxt = S_ISSUE;
        else
          adv = 1'b1;
      end
      state == S_ISSUE: begin
        state_nxt = S_WAIT;
      end
      state == S_WAIT: begin
        if (draw_done) begin
          adv       = 1'b1;
          state_nxt = (|dirty_nxt) ? S_SCAN : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      dirty      <= '1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      draw_start <= 1'b0;
      draw_col   <= '0;
      draw_row   <= '0;
      draw_code  <= '0;
    end else begin
      state      <= state_nxt;
      dirty      <= dirty_nxt;
      busy       <= (state_nxt != S_IDLE);
      draw_start <= hit;
      frame_done <= (state == S_WAIT) && draw_done
                    && !(|dirty_nxt);
      if (hit) begin
        draw_col  <= pcol;
        draw_row  <= prow;
        draw_code <= cbuf[pidx];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CELLS; i++)
        cbuf[i] <= RESET_CODE;
    end else if (wr_en) begin
      cbuf[cell_idx(wr_col, wr_row)] <= wr_code;
    end
  end

endmodule
